four_bit_using_one_bit_comparator: RTL and testbench

Registered 4-bit magnitude comparator built from four 1-bit comparator cells combined MSB-first. It reports whether unsigned operand `a` is less than, equal to, or greater than `b` as a one-hot flag triple. It is a leaf datapath block for control logic that needs a clocked compare result with a valid qualifier.

---
 rtl/comp_pkg.sv | 21 ++
 rtl/one_bit_comp.sv | 14 +
 rtl/four_bit_using_one_bit_comparator.sv | 78 +++++++
 tb/tb_four_bit_using_one_bit_comparator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared types and constants for the 4-bit magnitude comparator.
// Result flags are packed {lt, eq, gt} so the constants read MSB-first.
package comp_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } comp_res_t;

  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // MSB-first priority combine: a lower bit only decides when every higher bit is equal.
  function automatic logic msb_first(input logic [3:0] d, input logic [3:0] e);
    return d[3] | (e[3] & d[2]) | (e[3] & e[2] & d[1]) | (e[3] & e[2] & e[1] & d[0]);
  endfunction

endpackage

// File: rtl/one_bit_comp.sv
// Combinational 1-bit comparator cell producing less/equal/greater flags.
module one_bit_comp (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);

  assign lt = ~a & b;
  assign eq = ~(a ^ b);
  assign gt = a & ~b;

endmodule

// File: rtl/four_bit_using_one_bit_comparator.sv
// Registered 4-bit unsigned comparator built from four one_bit_comp cells.
// Optional 7485-style cascade inputs are enabled by FOUR_BIT_COMP_CASCADE_EN.
//
// Handshake: in_valid qualifies a/b on a rising edge; out_valid is high for
// exactly the following cycle. There is no ready: the consumer must take the
// result while out_valid is high. Flags hold their value while out_valid is low.
module four_bit_using_one_bit_comparator
  import comp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  output logic       lt,
  output logic       eq,
  output logic       gt
`ifdef FOUR_BIT_COMP_CASCADE_EN
  ,
  input  logic       casc_lt,
  input  logic       casc_eq,
  input  logic       casc_gt
`endif
);

  logic [3:0] bit_lt;
  logic [3:0] bit_eq;
  logic [3:0] bit_gt;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    one_bit_comp u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .lt (bit_lt[i]),
      .eq (bit_eq[i]),
      .gt (bit_gt[i])
    );
  end

  logic      all_eq;
  comp_res_t res_d;
  comp_res_t res_q;
  logic      out_valid_q;

  assign all_eq = &bit_eq;

  always_comb begin
    res_d = RES_NONE;
    if (!all_eq) begin
      res_d.lt = msb_first(bit_lt, bit_eq);
      res_d.gt = msb_first(bit_gt, bit_eq);
    end else begin
`ifdef FOUR_BIT_COMP_CASCADE_EN
      // Equal operands defer to the cascade, copied verbatim even if not one-hot.
      res_d = {casc_lt, casc_eq, casc_gt};
`else
      res_d = RES_EQ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= RES_NONE;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) res_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign lt        = res_q.lt;
  assign eq        = res_q.eq;
  assign gt        = res_q.gt;

endmodule

// File: tb/tb_four_bit_using_one_bit_comparator.sv
// Scoreboard bench for four_bit_using_one_bit_comparator: driver pushes the
// expected flags, a monitor pops and compares whenever out_valid is high.
module tb_four_bit_using_one_bit_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       out_valid;
  logic       lt, eq, gt;
`ifdef FOUR_BIT_COMP_CASCADE_EN
  logic [2:0] casc = 3'b010;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last_res = 3'b000;

  four_bit_using_one_bit_comparator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
`ifdef FOUR_BIT_COMP_CASCADE_EN
    ,
    .casc_lt   (casc[2]),
    .casc_eq   (casc[1]),
    .casc_gt   (casc[0])
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned integer comparison, flags packed {lt,eq,gt}.
  function automatic logic [2:0] model(input int x, input int y, input logic [2:0] c);
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
`ifdef FOUR_BIT_COMP_CASCADE_EN
    return c;
`else
    return (c == c) ? 3'b010 : 3'b010;
`endif
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (a=%0d b=%0d t=%0t)", name, act, exp, a, b, $time);
    end
  endtask

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic v);
    logic [2:0] c;
    @(negedge clk);
    a = ta;
    b = tb_;
    in_valid = v;
`ifdef FOUR_BIT_COMP_CASCADE_EN
    c = 3'b100 >> $urandom_range(0, 2);
    casc = c;
`else
    c = 3'b010;
`endif
    if (v) exp_q.push_back(model(int'(ta), int'(tb_), c));
  endtask

  // Monitor
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_flags", {1'b0, out_valid, lt, eq, gt}, 4'b0000);
      last_res = 3'b000;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {1'b1, lt, eq, gt}, 4'b0000);
      end else begin
        last_res = exp_q.pop_front();
        check("result", {1'b0, lt, eq, gt}, {1'b0, last_res});
`ifndef FOUR_BIT_COMP_CASCADE_EN
        check("one_hot", {3'b000, $onehot({lt, eq, gt})}, 4'b0001);
`endif
      end
    end else begin
      check("hold", {1'b0, lt, eq, gt}, {1'b0, last_res});
    end
  end

  initial begin
    // Reset held with live inputs: outputs stay cleared.
    in_valid = 1'b1;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    #1;
    check("reset_async", {out_valid, lt, eq, gt}, 4'b0000);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // First pair after release, then exhaustive sweep.
    drive(4'd3, 4'd8, 1'b1);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        drive(4'(i), 4'(j), 1'b1);

    // MSB dominance.
    drive(4'b1000, 4'b0111, 1'b1);
    drive(4'b0111, 4'b1000, 1'b1);

    // Valid gating: lt must hold while new operands are presented unqualified.
    drive(4'd2, 4'd9, 1'b1);
    drive(4'd9, 4'd2, 1'b0);
    @(posedge clk);
    #2;
    check("gate_hold", {out_valid, lt, eq, gt}, 4'b0100);

`ifdef FOUR_BIT_COMP_CASCADE_EN
    @(negedge clk);
    a = 4'd6; b = 4'd6; casc = 3'b001; in_valid = 1'b1;
    exp_q.push_back(3'b001);
    @(negedge clk);
    a = 4'd7; b = 4'd6; casc = 3'b100; in_valid = 1'b1;
    exp_q.push_back(3'b001);
`endif

    // Randomized traffic with random valid gaps.
    for (int k = 0; k < 300; k++)
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));

    // Reset mid-stream: the second compare is in flight when reset hits.
    drive(4'd4, 4'd3, 1'b1);
    @(negedge clk);
    a = 4'd1; b = 4'd2; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_async", {out_valid, lt, eq, gt}, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("midreset_discard", {out_valid, lt, eq, gt}, 4'b0000);
    drive(4'd11, 4'd11, 1'b1);
    drive(4'd5, 4'd1, 1'b1);
    drive(4'd0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", 4'(exp_q.size()), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
